// File: rtl/bilbo_register_if.sv
// rtl/bilbo_register_if.sv - mode/data/scan/signature bundle of the BILBO register
interface bilbo_register_if #(
  parameter int N  = 16,
  parameter int CW = 8
);
  logic [2:0]    mode;
  logic [N-1:0]  in;
  logic          si;
  logic [N-1:0]  golden;
  logic [N-1:0]  outREG;
  logic          so;
  logic [CW-1:0] count;
  logic          match;

  modport master (
    output mode, in, si, golden,
    input  outREG, so, count, match
  );

  modport slave (
    input  mode, in, si, golden,
    output outREG, so, count, match
  );
endinterface

// File: rtl/bilbo_register.sv
// rtl/bilbo_register.sv - multi-mode register: load, scan, PRPG, MISR with session counter and signature compare
module bilbo_register #(
  parameter int           N    = 16,
  parameter logic [N-1:0] POLY = 16'hB400,
  parameter logic [N-1:0] SEED = 16'h0001,
  parameter int           CW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  bilbo_register_if.slave   bus
);
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SCAN  = 3'b010;
  localparam logic [2:0] MODE_PRPG  = 3'b011;
  localparam logic [2:0] MODE_MISR  = 3'b100;
  localparam logic [2:0] MODE_CLEAR = 3'b101;
  localparam logic [CW-1:0] CMAX    = '1;

  logic [N-1:0]  state;
  logic [N-1:0]  state_nxt;
  logic [N-1:0]  lfsr_step;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_sat;
  logic          fb;

  assign fb        = ^(state & POLY);
  assign lfsr_step = {state[N-2:0], fb};
  assign cnt_sat   = (cnt == CMAX) ? cnt : cnt + 1'b1;

  // Unlisted modes (000, 110, 111) fall through to hold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (bus.mode)
      MODE_LOAD: begin
        state_nxt = bus.in;
        cnt_nxt   = '0;
      end
      MODE_SCAN: state_nxt = {state[N-2:0], bus.si};
      MODE_PRPG: begin
        state_nxt = (state == '0) ? SEED : lfsr_step;
        cnt_nxt   = cnt_sat;
      end
      MODE_MISR: begin
        state_nxt = lfsr_step ^ bus.in;
        cnt_nxt   = cnt_sat;
      end
      MODE_CLEAR: begin
        state_nxt = '0;
        cnt_nxt   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.outREG = state;
  assign bus.so     = state[N-1];
  assign bus.count  = cnt;
  assign bus.match  = (state == bus.golden);
endmodule
